// File: rtl/rr_encoder_arbiter8_if.sv
// rtl/rr_encoder_arbiter8_if.sv - request/grant bus between requesters and the round-robin arbiter
// Requests and grant are active-low one-per-requester vectors; y is the binary owner index.
interface rr_encoder_arbiter8_if;
   logic       e;
   logic [7:0] i;
   logic       done;
   logic [2:0] y;
   logic       v;
   logic [7:0] g;
   logic       to;

   modport master (
      output e,
      output i,
      output done,
      input  y,
      input  v,
      input  g,
      input  to
   );

   modport slave (
      input  e,
      input  i,
      input  done,
      output y,
      output v,
      output g,
      output to
   );
endinterface

// File: rtl/rr_encoder_arbiter8.sv
// rtl/rr_encoder_arbiter8.sv - eight-way round-robin arbiter with registered active-low grant
// Grants are held until DONE, request withdrawal, enable drop or the MAX_HOLD timeout.
module rr_encoder_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   rr_encoder_arbiter8_if.slave       bus
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] y_q, y_d;
   logic       v_q, v_d;
   logic [7:0] g_q, g_d;
   logic       to_q, to_d;

   logic [7:0]  req;
   logic [15:0] req_dbl;
   logic [7:0]  req_rot;
   logic [2:0]  win_off;
   logic [2:0]  win;
   logic        any_req;
   logic        grant_now;
   logic        rel_hard;
   logic        rel_to;
   logic        release_now;

   // Rotate requests so the pointer position lands at bit 0, then take the lowest set bit.
   assign req     = ~bus.i;
   assign req_dbl = {req, req} >> ptr_q;
   assign req_rot = req_dbl[7:0];
   assign any_req = |req;

   always_comb begin
      win_off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_off = 3'(k);
         end
      end
   end

   assign win       = ptr_q + win_off;
   assign grant_now = bus.e && any_req;

   assign rel_hard    = bus.done || bus.i[y_q] || !bus.e;
   assign rel_to      = (cnt_q == HOLD_LAST);
   assign release_now = rel_hard || rel_to;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= 8'd0;
         y_q     <= 3'd0;
         v_q     <= 1'b0;
         g_q     <= 8'hFF;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         v_q     <= v_d;
         g_q     <= g_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant_now)   state_d = ST_GRANT;
         ST_GRANT: if (release_now) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      y_d   = y_q;
      v_d   = 1'b0;
      g_d   = 8'hFF;
      to_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_now) begin
               y_d   = win;
               v_d   = 1'b1;
               g_d   = ~(8'b1 << win);
               cnt_d = 8'd0;
               ptr_d = win + 3'd1;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               // A timeout only counts when nothing else ended the grant this cycle.
               to_d = rel_to && !rel_hard;
            end else begin
               v_d   = 1'b1;
               g_d   = g_q;
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            v_d = 1'b0;
         end
      endcase
   end

   assign bus.y  = y_q;
   assign bus.v  = v_q;
   assign bus.g  = g_q;
   assign bus.to = to_q;

endmodule

// File: doc/rr_encoder_arbiter8.md
# rr_encoder_arbiter8

Round-robin arbiter that shares one downstream resource among eight active-low requesters, using the same encoding as the 8-to-3 encoder (I[k]=0 means requester k active, Y = binary index). It sits in front of the encoder datapath. It produces a registered grant with enable gating, a rotating priority pointer, release on DONE or request withdrawal, and a hold-timeout limit per grant.

## Interface
- MAX_HOLD, 16, maximum cycles one grant may be held; legal 1..256
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- E  in  1  arbiter enable; 0 blocks new grants and ends a current grant
- I  in  8  requests, active-low (I[k]=0 → requester k requests)
- DONE  in  1  owner releases grant (active-high, sampled only in GRANT)
- Y  out  3  index of current owner, registered
- V  out  1  grant valid, registered
- G  out  8  one-hot grant, active-low (G[Y]=0 while V=1, else 8'hFF)
- TO  out  1  one-cycle pulse: grant ended by timeout

## Operation
- Two states: IDLE, GRANT. Internal: PTR[2:0] priority pointer, CNT[7:0] hold counter.
- IDLE: if E=1 and I≠8'hFF, the winner is the first k with I[k]=0, searching k = PTR, PTR+1, … with mod-8 wrap. At the next edge: state=GRANT, Y=k, V=1, G[k]=0, CNT=0, PTR=(k+1) mod 8. Otherwise remain IDLE with outputs unchanged at idle values.
- GRANT: release when any of the following is true in the current cycle:
  - DONE=1
  - I[Y]=1 (the owner withdrew its request)
  - E=0
  - CNT==MAX_HOLD-1 (timeout)
- If no release condition holds, CNT increments.
- On release, at the next edge: state=IDLE, V=0, G=8'hFF. Y holds its last value. TO=1 for exactly that one cycle only if the timeout was the sole release cause. DONE, withdrawal and E=0 take precedence, so TO=0 if any of them coincides with the timeout.
- Requests from other requesters during GRANT are ignored. No preemption.
- PTR changes only on grant. A released owner has lowest priority in the next arbitration.

## Timing
- Reset (RST=1 at an edge): state=IDLE, Y=3'd0, V=0, G=8'hFF, TO=0, PTR=0, CNT=0.
- RST overrides all other inputs, including during GRANT. The grant drops at that edge.
- Grant latency: a request sampled in IDLE at edge n is granted with V=1 from edge n+1.
- Maximum hold: V=1 for at most MAX_HOLD consecutive cycles. With MAX_HOLD=1, every grant lasts exactly one cycle.
- Minimum gap: at least one cycle with V=0 between consecutive grants, including to different requesters.
- Back-to-back throughput with a single persistent requester and MAX_HOLD=M: M cycles granted, 1 cycle idle, repeating.
- All outputs are registered, so there is no combinational path from I, E or DONE to the outputs.
- G and Y/V are always consistent: G == ~(8'b1<<Y) when V=1, and G == 8'hFF when V=0.

## Test plan
- Reset, then E=1, I=8'hFF for 10 cycles → V=0, G=8'hFF, Y=0, TO=0 throughout.
- Reset, E=1, apply in turn I=8'b11111110, 8'b11111101, … 8'b01111111, each held until granted and then released with DONE=1 → Y=0..7 in order, G mirrors I, each grant 1 cycle after request, one idle cycle between grants.
- I=8'b00000000 held, E=1, DONE pulsed 1 cycle after each grant → grant order 0,1,2,…,7,0 (round-robin wrap), PTR wraps after 7.
- MAX_HOLD=4, I=8'b11110111, DONE=0 → Y=3, V=1 for exactly 4 cycles, then V=0 with TO=1 for one cycle, then re-grant to 3. Same run with DONE=1 in the 4th cycle → TO stays 0.
- Grant held by requester 5. Cases:
  - Set I[5]=1 → V=0 at the next edge.
  - Instead drop E to 0 → V=0 at the next edge, and no re-grant until E=1.
- Assert RST mid-GRANT (Y=6, V=1) → next edge V=0, G=8'hFF, Y=0. With I=8'b00000000 afterwards, the first grant is Y=0 (PTR reset).
